// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: sequencer states and the
// captured command layout.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 2;
    localparam int unsigned DEF_DATA_W = 8;
    // Wide enough to name any of up to 8 requesters.
    localparam int unsigned OWNER_W    = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StResp
    } arb_state_e;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [OWNER_W-1:0]    owner;
    } arb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: combinational search from a pointer that advances
// past the winner only when the grant is consumed.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       update,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CW    = IDX_W + 1;

    logic [IDX_W-1:0] ptr_q;
    logic [CW-1:0]    cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
            end
        end
    end

    assign grant_any = found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (update) begin
            ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing a single-port memory between NUM_REQ requesters.
// One command is in flight at a time; read data returns to its owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_rst,
    output logic                      mem_wen,
    output logic                      mem_ren,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q;
    arb_cmd_t           cmd_q;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               ready_en;
    logic               handshake;

    // Grants are offered only while idle and after the memory has left reset.
    assign ready_en  = (state_q == StIdle) && !mem_rst;
    assign req_ready = ready_en ? grant : '0;
    assign handshake = ready_en && grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .update    (handshake),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rst <= 1'b1;
        end else begin
            mem_rst <= 1'b0;
        end
    end

    // The capture register doubles as the memory address/data drivers, so both
    // hold their last value between commands.
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        cmd_q <= '{
                            write: req_write[grant_idx],
                            addr:  req_addr[grant_idx*ADDR_W +: ADDR_W],
                            wdata: req_wdata[grant_idx*DATA_W +: DATA_W],
                            owner: OWNER_W'(grant_idx)
                        };
                        mem_wen <= req_write[grant_idx];
                        mem_ren <= !req_write[grant_idx];
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    mem_wen <= 1'b0;
                    mem_ren <= 1'b0;
                    state_q <= cmd_q.write ? StIdle : StRdWait;
                end
                StRdWait: begin
                    rsp_rdata <= mem_rdata;
                    rsp_valid <= NUM_REQ'(1) << cmd_q.owner;
                    state_q   <= StResp;
                end
                StResp: begin
                    rsp_valid <= '0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 4x8 memory device plus a transaction-level reference
// that predicts grants, strobes and responses from the command timing rules.
module tb_mem_arbiter;

    localparam int N = 2;

    typedef struct packed {
        logic       write;
        logic [1:0] addr;
        logic [7:0] data;
    } tcmd_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [2*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [7:0]     rsp_rdata, mem_wdata, mem_rdata;
    logic [1:0]     mem_addr;
    logic           mem_rst, mem_wen, mem_ren;
    logic [7:0]     mem_arr [4];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rand_drop = 1'b0;

    tcmd_t q0[$];
    tcmd_t q1[$];

    // Reference model state.
    logic [7:0] ref_mem [4];
    int         ptr_m, free_at, wen_cyc, ren_cyc, rsp_cyc, rsp_owner;
    logic [7:0] rsp_data, last_wdata;
    logic [1:0] last_addr;
    bit         mrst_m;

    int         hs_cyc[$];
    int         hs_idx[$];
    int         rsp_own[$];
    int         rsp_at[$];
    logic [7:0] rsp_dat[$];

    mem_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (2),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_rst   (mem_rst),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: registered read, re-initialised to 0xFF by mem_rst.
    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < 4; i++) mem_arr[i] <= 8'hFF;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_wen) mem_arr[mem_addr] <= mem_wdata;
            if (mem_ren) mem_rdata <= mem_arr[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ptr_m      = 0;
        free_at    = 0;
        wen_cyc    = -1;
        ren_cyc    = -1;
        rsp_cyc    = -1;
        rsp_owner  = 0;
        rsp_data   = 8'h00;
        last_addr  = 2'd0;
        last_wdata = 8'h00;
        mrst_m     = 1'b1;
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
        q0.delete();
        q1.delete();
    endtask

    task automatic push_cmd(input int r, input bit w, input int a, input int d);
        tcmd_t c;
        c.write = w;
        c.addr  = 2'(a);
        c.data  = 8'(d);
        if (r == 0) q0.push_back(c);
        else        q1.push_back(c);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            tcmd_t c;
            bit    have;
            bit    v;
            c    = '0;
            have = 1'b0;
            if (i == 0 && q0.size() > 0) begin
                have = 1'b1;
                c    = q0[0];
            end else if (i == 1 && q1.size() > 0) begin
                have = 1'b1;
                c    = q1[0];
            end
            v = have && (!rand_drop || $urandom_range(3) != 0);
            req_valid[i]        = v;
            req_write[i]        = v ? c.write : 1'($urandom_range(1));
            req_addr[i*2 +: 2]  = v ? c.addr : 2'($urandom_range(3));
            req_wdata[i*8 +: 8] = v ? c.data : 8'($urandom_range(255));
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;
        int           g;
        tcmd_t        c;
        exp_ready = '0;
        exp_rsp   = '0;
        g         = -1;
        if ((req_valid & req_ready) != '0) begin
            hs_cyc.push_back(cyc);
            hs_idx.push_back(req_ready[1] ? 1 : 0);
        end
        if (rsp_valid != '0) begin
            rsp_own.push_back(rsp_valid[1] ? 1 : 0);
            rsp_at.push_back(cyc);
            rsp_dat.push_back(rsp_rdata);
        end
        if (!rst_n) begin
            check_eq("rst_mem_rst", 32'(mem_rst), 32'd1);
            check_eq("rst_outputs",
                     32'({req_ready, rsp_valid, rsp_rdata, mem_wen, mem_ren, mem_addr, mem_wdata}),
                     32'd0);
            return;
        end
        if (!mrst_m && cyc >= free_at) begin
            for (int k = 0; k < N; k++) begin
                int r;
                r = (ptr_m + k) % N;
                if (req_valid[r] && g < 0) begin
                    g            = r;
                    exp_ready[r] = 1'b1;
                end
            end
        end
        if (cyc == rsp_cyc) exp_rsp[rsp_owner] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("mem_rst", 32'(mem_rst), 32'(mrst_m));
        check_eq("mem_wen", 32'(mem_wen), 32'(cyc == wen_cyc));
        check_eq("mem_ren", 32'(mem_ren), 32'(cyc == ren_cyc));
        check_eq("mem_addr", 32'(mem_addr), 32'(last_addr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(last_wdata));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (cyc == rsp_cyc) check_eq("rsp_rdata", 32'(rsp_rdata), 32'(rsp_data));
        if (g >= 0) begin
            if (g == 0) c = q0.pop_front();
            else        c = q1.pop_front();
            ptr_m      = (g + 1) % N;
            last_addr  = c.addr;
            last_wdata = c.data;
            if (c.write) begin
                wen_cyc          = cyc + 1;
                ref_mem[c.addr]  = c.data;
                free_at          = cyc + 2;
            end else begin
                ren_cyc   = cyc + 1;
                rsp_cyc   = cyc + 3;
                rsp_owner = g;
                rsp_data  = ref_mem[c.addr];
                free_at   = cyc + 4;
            end
        end
    endtask

    task automatic step();
        drive_inputs();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (rst_n) mrst_m = 1'b0;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cyc < free_at) && b < budget) begin
            step();
            b++;
        end
        check_eq("drain_in_budget", 32'(b < budget), 32'd1);
    endtask

    initial begin
        int         hb;
        int         rb;
        logic [7:0] wd [4];

        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        repeat (3) step();

        // Reset release with a read already pending: no grant while mem_rst is high.
        push_cmd(0, 1'b0, 2, 8'h3C);
        rst_n = 1'b1;
        rb = rsp_dat.size();
        step();
        drain(50);
        check_eq("rd2_count", 32'(rsp_dat.size() - rb), 32'd1);
        if (rsp_dat.size() - rb == 1) check_eq("rd2_data", 32'(rsp_dat[rb]), 32'hFF);

        // Write then read from requester 0.
        hb = hs_cyc.size();
        rb = rsp_dat.size();
        push_cmd(0, 1'b1, 1, 8'hA5);
        push_cmd(0, 1'b0, 1, 8'h5A);
        drain(50);
        check_eq("wr_rd_hs_count", 32'(hs_cyc.size() - hb), 32'd2);
        check_eq("wr_rd_rsp_count", 32'(rsp_dat.size() - rb), 32'd1);
        if (hs_cyc.size() - hb == 2 && rsp_dat.size() - rb == 1) begin
            check_eq("wr_to_rd_gap", 32'(hs_cyc[hb+1] - hs_cyc[hb]), 32'd2);
            check_eq("rd_latency", 32'(rsp_at[rb] - hs_cyc[hb+1]), 32'd3);
            check_eq("rd_owner", 32'(rsp_own[rb]), 32'd0);
            check_eq("rd_data_a5", 32'(rsp_dat[rb]), 32'hA5);
        end

        // One grant to requester 1 moves the pointer to 0; it must hold while idle.
        push_cmd(1, 1'b0, 0, 8'h00);
        drain(50);
        repeat (5) step();

        // Contention: both continuously valid, grants alternate starting at 0.
        hb = hs_cyc.size();
        for (int k = 0; k < 4; k++) begin
            push_cmd(0, 1'b1, 0, 8'h11);
            push_cmd(1, 1'b1, 3, 8'h22);
        end
        drain(100);
        check_eq("cont_hs_count", 32'(hs_cyc.size() - hb), 32'd8);
        if (hs_cyc.size() - hb == 8) begin
            for (int k = 0; k < 8; k++) begin
                check_eq("cont_grant_idx", 32'(hs_idx[hb+k]), 32'(k % 2));
                if (k > 0) check_eq("cont_gap", 32'(hs_cyc[hb+k] - hs_cyc[hb+k-1]), 32'd2);
            end
        end

        // Response routing: requester 1 reads while requester 0 waits behind it.
        hb = hs_cyc.size();
        rb = rsp_dat.size();
        push_cmd(1, 1'b0, 3, 8'h00);
        step();
        push_cmd(0, 1'b0, 0, 8'h00);
        drain(50);
        check_eq("route_hs_count", 32'(hs_cyc.size() - hb), 32'd2);
        check_eq("route_rsp_count", 32'(rsp_dat.size() - rb), 32'd2);
        if (hs_cyc.size() - hb == 2 && rsp_dat.size() - rb == 2) begin
            check_eq("route_first_idx", 32'(hs_idx[hb]), 32'd1);
            check_eq("route_second_idx", 32'(hs_idx[hb+1]), 32'd0);
            check_eq("route_wait_gap", 32'(hs_cyc[hb+1] - hs_cyc[hb]), 32'd4);
            check_eq("route_owner", 32'(rsp_own[rb]), 32'd1);
            check_eq("route_data_22", 32'(rsp_dat[rb]), 32'h22);
            check_eq("route_data_11", 32'(rsp_dat[rb+1]), 32'h11);
        end

        // Reset asserted during the read-wait cycle abandons the read.
        push_cmd(0, 1'b0, 1, 8'h00);
        for (int b = 0; b < 20 && cyc != ren_cyc + 1; b++) step();
        check_eq("rdwait_reached", 32'(cyc), 32'(ren_cyc + 1));
        rb = rsp_dat.size();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_mem_rst", 32'(mem_rst), 32'd1);
        check_eq("async_rst_clear",
                 32'({req_ready, rsp_valid, rsp_rdata, mem_wen, mem_ren, mem_addr, mem_wdata}),
                 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        for (int a = 0; a < 4; a++) push_cmd(0, 1'b0, a, 8'h00);
        drain(100);
        check_eq("post_rst_rsp_count", 32'(rsp_dat.size() - rb), 32'd4);
        if (rsp_dat.size() - rb == 4) begin
            for (int a = 0; a < 4; a++) check_eq("post_rst_ff", 32'(rsp_dat[rb+a]), 32'hFF);
        end

        // Back-to-back: 4 writes then 4 reads from one requester.
        hb = hs_cyc.size();
        rb = rsp_dat.size();
        for (int a = 0; a < 4; a++) begin
            wd[a] = 8'($urandom_range(255));
            push_cmd(1, 1'b1, a, int'(wd[a]));
        end
        for (int a = 0; a < 4; a++) push_cmd(1, 1'b0, a, 8'h00);
        drain(100);
        check_eq("b2b_hs_count", 32'(hs_cyc.size() - hb), 32'd8);
        check_eq("b2b_rsp_count", 32'(rsp_dat.size() - rb), 32'd4);
        if (hs_cyc.size() - hb == 8 && rsp_dat.size() - rb == 4) begin
            for (int k = 1; k < 8; k++)
                check_eq("b2b_gap", 32'(hs_cyc[hb+k] - hs_cyc[hb+k-1]), (k <= 4) ? 32'd2 : 32'd4);
            for (int a = 0; a < 4; a++) check_eq("b2b_data", 32'(rsp_dat[rb+a]), 32'(wd[a]));
        end

        // Random traffic with requesters dropping valid at will.
        rand_drop = 1'b1;
        repeat (400) begin
            if (q0.size() < 3 && $urandom_range(2) == 0)
                push_cmd(0, 1'($urandom_range(1)), int'($urandom_range(3)),
                         int'($urandom_range(255)));
            if (q1.size() < 3 && $urandom_range(2) == 0)
                push_cmd(1, 1'($urandom_range(1)), int'($urandom_range(3)),
                         int'($urandom_range(255)));
            step();
        end
        rand_drop = 1'b0;
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares the single-port 4 x 8-bit memory between NUM_REQ requesters. Accepts one read or write command at a time through a valid/ready handshake, drives the memory's write-enable, read-enable, address and write-data strobes, and returns read data to the owning requester. Also generates the memory's active-high reset pulse from the system reset. Sits between the requester masters and the memory on the shared bus.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 2, memory address width (4 entries)
- DATA_W, 8, memory data width
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_write  in  NUM_REQ  per-requester command type: 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data, slice i
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid & ready
- rsp_valid  out  NUM_REQ  one-hot, one-cycle read-response strobe to owner
- rsp_rdata  out  DATA_W  read data, meaningful while any rsp_valid bit is high
- mem_rst  out  1  active-high memory reset
- mem_wen  out  1  memory write enable
- mem_ren  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, registered by memory one edge after mem_ren

## Operation
- Reset: clock and reset are as decided: one clock, asynchronous active-low reset. While rst_n = 0, all outputs are 0 except mem_rst = 1. State = IDLE, priority pointer = 0, captured command cleared.
- mem_rst flop: set by reset, cleared at the first clk edge after rst_n rises. req_ready is held at 0 while mem_rst = 1.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE:
  - Grant: the first requester with req_valid = 1, searching from the pointer upward modulo NUM_REQ. Only that bit of req_ready is high (combinational).
  - On handshake, capture write, addr, wdata and the grant index, set pointer = index + 1 mod NUM_REQ, then go to ISSUE.
  - With no valid requester, stay in IDLE and leave the pointer unchanged.
- ISSUE: drive mem_addr and mem_wdata from the capture, with mem_wen = write and mem_ren = !write, for exactly one cycle.
  - Write: go to IDLE.
  - Read: go to RD_WAIT.
- RD_WAIT: mem_rdata is valid this cycle. Register it into rsp_rdata, then go to RESP.
- RESP: assert rsp_valid[index] for one cycle, then go to IDLE. There is no back-pressure on the response.
- Only one command is outstanding, so read-after-write to the same address always returns the new data.
- mem_addr and mem_wdata hold their last value outside ISSUE. mem_wen and mem_ren are 0 outside ISSUE.
- A requester may drop req_valid before the handshake without penalty.
- Payload is sampled only in the handshake cycle.

## Timing
- Write: handshake in cycle N, mem_wen = 1 in N+1, memory updated at the end of N+1, next grant possible in N+2.
- Read: handshake in N, mem_ren = 1 in N+1, mem_rdata valid in N+2, rsp_valid and rsp_rdata in N+3, next grant possible in N+4.
- Peak throughput:
  - one write per 2 cycles;
  - one read per 4 cycles.
- All outputs are registered except req_ready, which decodes the IDLE state, the pointer, req_valid and mem_rst.
- Reset mid-operation: the command in flight is abandoned, no rsp_valid is produced, and memory contents are re-initialised by mem_rst.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, ..., NUM_REQ-1, 0, and so on. The worst-case wait is (NUM_REQ-1) command slots.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, RD_WAIT, RESP);
  - default ADDR_W and DATA_W constants;
  - packed command struct (write, addr, wdata, owner index).
- Sub-module rr_arbiter, parameterised by NUM_REQ:
  - combinational rotate-priority search producing a one-hot grant and its index;
  - the pointer register, which advances only on an update strobe.
- mem_arbiter contains the FSM, the capture registers, the response register and the mem_rst flop.

## Test plan
- Reset release: rst_n low for 3 cycles, then high.
  - mem_rst = 1 until the first edge after release.
  - All other outputs are 0 during reset.
  - req_ready stays 0 while mem_rst = 1.
  - A read of address 2 returns 0xFF.
- Single write then read, requester 0:
  - Stimulus: write 0xA5 to address 1, then read address 1.
  - mem_wen is high 1 cycle after the write handshake.
  - rsp_valid[0] is high with rsp_rdata = 0xA5 exactly 3 cycles after the read handshake.
- Contention: both requesters hold valid continuously.
  - Requester 0 writes 0x11 to address 0; requester 1 writes 0x22 to address 3.
  - Grants alternate 0, 1, 0, 1.
  - The pointer holds while the bus is idle.
- Read response routing: requester 1 reads address 3 while requester 0 waits.
  - Only rsp_valid[1] pulses, with rsp_rdata = 0x22.
  - Requester 0 is granted in the cycle after RESP.
- Reset mid-read: drop rst_n during RD_WAIT.
  - Outputs clear immediately and no rsp_valid is produced.
  - After release, the memory reads back 0xFF at all 4 addresses.
- Back-to-back throughput: 4 writes from one requester, then 4 reads.
  - Handshakes occur every 2 cycles for the writes and every 4 cycles for the reads.
  - The read data matches the written values.
